pr_status_monitor: RTL and testbench

Consumes the raw 3-bit status bus from the Partial Reconfiguration controller IP and produces the software-visible PR status in SW encoding. Adds glitch qualification, a PR sequencing FSM, a timeout watchdog, sticky error capture and completion/error event pulses. It sits in the port gasket between the PR controller IP and the PR CSR block.

---
 rtl/pr_status_monitor.sv | 187 ++++++++++++++++++
 tb/tb_pr_status_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_status_monitor.sv
// pr_status_monitor
// Turns the raw 3-bit status bus of the Partial Reconfiguration controller IP
// into the software-visible PR status (SW encoding). It sits in the port
// gasket between the PR controller IP and the PR CSR block. It adds glitch
// qualification of the raw status, a PR sequencing FSM, a timeout watchdog,
// sticky error capture and completion/error event pulses.
//
// Ports:
//   clk             clock, all logic synchronous to it
//   rst_n           asynchronous active-low reset
//   pr_start_req    1-cycle pulse: software started a PR operation
//   pr_ctrl_status  raw controller status (000 nreset, 001 busy, 010 in
//                   progress, 011 successful, 100 error)
//   crc_err_in      controller CRC error level
//   incompat_err_in controller incompatible-bitstream level
//   sw_clr_err      1-cycle pulse: clear sticky error
//   sw_status       SW encoding (000 powerup, 001 PR error, 010 CRC error,
//                   011 incompatible, 100 in progress, 101 successful,
//                   110 busy)
//   pr_busy         high in ARMED or RUN
//   pr_done_pulse   1-cycle pulse on entry to DONE
//   pr_err_pulse    1-cycle pulse on entry to ERR
//   timeout_err     sticky, set when ERR is entered by the watchdog
//   start_nack      1-cycle pulse when pr_start_req is ignored
//
// state | meaning
// IDLE  | no operation; sw_status mirrors the qualified raw status
// ARMED | start seen, waiting for the controller to report "in progress"
// RUN   | reconfiguration in progress
// DONE  | controller reported success
// ERR   | error captured; sw_status frozen until software clears it
module pr_status_monitor #(
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pr_start_req,
  input  logic [2:0] pr_ctrl_status,
  input  logic       crc_err_in,
  input  logic       incompat_err_in,
  input  logic       sw_clr_err,
  output logic [2:0] sw_status,
  output logic       pr_busy,
  output logic       pr_done_pulse,
  output logic       pr_err_pulse,
  output logic       timeout_err,
  output logic       start_nack
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  localparam logic [2:0] RAW_NRESET  = 3'b000;
  localparam logic [2:0] RAW_RUNNING = 3'b010;
  localparam logic [2:0] RAW_SUCCESS = 3'b011;
  localparam logic [2:0] RAW_ERROR   = 3'b100;

  localparam logic [2:0] SW_PR_ERR   = 3'b001;
  localparam logic [2:0] SW_CRC_ERR  = 3'b010;
  localparam logic [2:0] SW_INCOMPAT = 3'b011;
  localparam logic [2:0] SW_IN_PROG  = 3'b100;
  localparam logic [2:0] SW_SUCCESS  = 3'b101;
  localparam logic [2:0] SW_BUSY     = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_RUN, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    last_raw, qual;
  logic [3:0]    run_cnt, run_cnt_nxt;
  logic [TW-1:0] tcnt;
  logic          timeout_hit, to_entry, nack_nxt;
  logic          qual_fail;

  function automatic logic [2:0] map_raw(input logic [2:0] q);
    case (q)
      3'b001:  map_raw = SW_BUSY;
      3'b010:  map_raw = SW_IN_PROG;
      3'b011:  map_raw = SW_SUCCESS;
      3'b100:  map_raw = SW_PR_ERR;
      default: map_raw = 3'b000;
    endcase
  endfunction

  // Run length of identical raw samples, including the one taken this edge.
  always_comb begin
    run_cnt_nxt = 4'd1;
    if (pr_ctrl_status == last_raw)
      run_cnt_nxt = (run_cnt == 4'd15) ? 4'd15 : run_cnt + 4'd1;
  end

  // The counter value after this edge would reach TIMEOUT_CYCLES-1.
  assign timeout_hit = (32'(tcnt) + 32'd1) >= (TIMEOUT_CYCLES - 32'd1);
  assign qual_fail   = (qual == RAW_ERROR) || (qual == RAW_NRESET);

  // Terminal status is checked before the watchdog so it wins a tie.
  always_comb begin
    state_nxt = state;
    to_entry  = 1'b0;
    nack_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pr_start_req) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        nack_nxt = pr_start_req;
        if (qual_fail) state_nxt = S_ERR;
        else if (timeout_hit) begin
          state_nxt = S_ERR;
          to_entry  = 1'b1;
        end else if (qual == RAW_RUNNING) state_nxt = S_RUN;
      end
      S_RUN: begin
        nack_nxt = pr_start_req;
        if (qual == RAW_SUCCESS) state_nxt = S_DONE;
        else if (qual_fail) state_nxt = S_ERR;
        else if (timeout_hit) begin
          state_nxt = S_ERR;
          to_entry  = 1'b1;
        end
      end
      S_DONE: begin
        if (pr_start_req) state_nxt = S_ARMED;
        else if (qual == RAW_ERROR) state_nxt = S_ERR;
      end
      S_ERR: begin
        nack_nxt = pr_start_req;
        if (sw_clr_err) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      last_raw      <= 3'b000;
      run_cnt       <= 4'd0;
      qual          <= 3'b000;
      tcnt          <= '0;
      sw_status     <= 3'b000;
      pr_busy       <= 1'b0;
      pr_done_pulse <= 1'b0;
      pr_err_pulse  <= 1'b0;
      timeout_err   <= 1'b0;
      start_nack    <= 1'b0;
    end else begin
      last_raw <= pr_ctrl_status;
      run_cnt  <= run_cnt_nxt;
      if (run_cnt_nxt >= STABLE) qual <= pr_ctrl_status;

      state <= state_nxt;

      if (state_nxt == S_ARMED && state != S_ARMED)
        tcnt <= '0;
      else if ((state == S_ARMED || state == S_RUN) && (32'(tcnt) < TIMEOUT_CYCLES))
        tcnt <= tcnt + TW'(1);

      pr_busy       <= (state_nxt == S_ARMED) || (state_nxt == S_RUN);
      pr_done_pulse <= (state_nxt == S_DONE) && (state != S_DONE);
      pr_err_pulse  <= (state_nxt == S_ERR) && (state != S_ERR);
      start_nack    <= nack_nxt;

      if (to_entry) timeout_err <= 1'b1;
      else if (state == S_ERR && sw_clr_err) timeout_err <= 1'b0;

      unique case (state_nxt)
        S_IDLE:  sw_status <= map_raw(qual);
        S_ARMED: sw_status <= SW_BUSY;
        S_RUN:   sw_status <= SW_IN_PROG;
        S_DONE:  sw_status <= SW_SUCCESS;
        S_ERR: begin
          // Error cause is captured once, on entry, and then held.
          if (state != S_ERR) begin
            if (incompat_err_in) sw_status <= SW_INCOMPAT;
            else if (crc_err_in) sw_status <= SW_CRC_ERR;
            else                 sw_status <= SW_PR_ERR;
          end
        end
        default: sw_status <= 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_status_monitor.sv
module tb_pr_status_monitor;

  localparam int S = 2;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pr_start_req;
  logic [2:0] pr_ctrl_status;
  logic       crc_err_in;
  logic       incompat_err_in;
  logic       sw_clr_err;
  logic [2:0] sw_status;
  logic       pr_busy;
  logic       pr_done_pulse;
  logic       pr_err_pulse;
  logic       timeout_err;
  logic       start_nack;

  pr_status_monitor #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .pr_start_req(pr_start_req),
    .pr_ctrl_status(pr_ctrl_status), .crc_err_in(crc_err_in),
    .incompat_err_in(incompat_err_in), .sw_clr_err(sw_clr_err),
    .sw_status(sw_status), .pr_busy(pr_busy), .pr_done_pulse(pr_done_pulse),
    .pr_err_pulse(pr_err_pulse), .timeout_err(timeout_err),
    .start_nack(start_nack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model. Phases: 0 idle, 1 armed, 2 run, 3 done, 4 err.
  int ph, qual, cyc, start_cyc;
  int hist[$];
  int e_sw, e_busy, e_done, e_err, e_to, e_nack;
  int idle_map[8] = '{0, 6, 4, 5, 1, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; qual = 0; hist.delete();
    e_sw = 0; e_busy = 0; e_done = 0; e_err = 0; e_to = 0; e_nack = 0;
  endtask

  task automatic model_step();
    int  np, elapsed;
    bit  late, to_now, all_eq;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    np = ph; to_now = 0; e_nack = 0;
    elapsed = cyc - start_cyc;
    late = (elapsed >= T - 1);
    case (ph)
      0: if (pr_start_req) begin np = 1; start_cyc = cyc; end
      1: begin
        e_nack = pr_start_req;
        if (qual == 4 || qual == 0) np = 4;
        else if (late) begin np = 4; to_now = 1; end
        else if (qual == 2) np = 2;
      end
      2: begin
        e_nack = pr_start_req;
        if (qual == 3) np = 3;
        else if (qual == 4 || qual == 0) np = 4;
        else if (late) begin np = 4; to_now = 1; end
      end
      3: begin
        if (pr_start_req) begin np = 1; start_cyc = cyc; end
        else if (qual == 4) np = 4;
      end
      default: begin
        e_nack = pr_start_req;
        if (sw_clr_err) np = 0;
      end
    endcase
    e_done = (np == 3 && ph != 3);
    e_err  = (np == 4 && ph != 4);
    e_busy = (np == 1 || np == 2);
    if (to_now) e_to = 1;
    else if (ph == 4 && sw_clr_err) e_to = 0;
    case (np)
      0: e_sw = idle_map[qual];
      1: e_sw = 6;
      2: e_sw = 4;
      3: e_sw = 5;
      default: if (ph != 4) e_sw = incompat_err_in ? 3 : (crc_err_in ? 2 : 1);
    endcase
    // A raw value is accepted once the last S samples all agree.
    hist.push_back(int'(pr_ctrl_status));
    if (hist.size() > S) void'(hist.pop_front());
    all_eq = (hist.size() == S);
    foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 0;
    if (all_eq) qual = hist[0];
    ph = np;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("sw_status", int'(sw_status), e_sw);
    chk("pr_busy", int'(pr_busy), e_busy);
    chk("pr_done_pulse", int'(pr_done_pulse), e_done);
    chk("pr_err_pulse", int'(pr_err_pulse), e_err);
    chk("timeout_err", int'(timeout_err), e_to);
    chk("start_nack", int'(start_nack), e_nack);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called right after a cycle() check, i.e. well away from both edges.
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_sw_status", int'(sw_status), 0);
    chk("async_rst_pr_busy", int'(pr_busy), 0);
    chk("async_rst_done", int'(pr_done_pulse), 0);
    chk("async_rst_err", int'(pr_err_pulse), 0);
    chk("async_rst_timeout", int'(timeout_err), 0);
    chk("async_rst_nack", int'(start_nack), 0);
  endtask

  initial begin
    int hold;
    int r;
    cyc = 0; start_cyc = 0;
    model_reset();
    rst_n = 1'b0; pr_start_req = 0; pr_ctrl_status = 3'b000;
    crc_err_in = 0; incompat_err_in = 0; sw_clr_err = 0;
    cycles(3);
    chk("reset_sw_status", int'(sw_status), 0);
    rst_n = 1'b1;

    // Nominal sequence
    pr_ctrl_status = 3'b001;
    cycles(4);
    chk("idle_busy_map", int'(sw_status), 6);
    pr_start_req = 1; cycle(); pr_start_req = 0;
    chk("armed_sw", int'(sw_status), 6);
    chk("armed_busy", int'(pr_busy), 1);
    cycles(4);
    pr_ctrl_status = 3'b010;
    cycles(20);
    chk("run_sw", int'(sw_status), 4);
    pr_ctrl_status = 3'b011;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("done_pulse_timing", int'(pr_done_pulse), (k == 3) ? 1 : 0);
    end
    chk("done_sw", int'(sw_status), 5);
    chk("done_busy", int'(pr_busy), 0);
    cycles(3);

    // Stale success must not complete a new operation
    pr_start_req = 1; cycle(); pr_start_req = 0;
    cycles(5);
    chk("stale_armed_sw", int'(sw_status), 6);
    pr_ctrl_status = 3'b010;
    cycles(3);
    chk("stale_run_sw", int'(sw_status), 4);
    pr_ctrl_status = 3'b011;
    cycles(3);
    chk("stale_done_sw", int'(sw_status), 5);

    // Glitch in RUN
    pr_start_req = 1; cycle(); pr_start_req = 0;
    pr_ctrl_status = 3'b010;
    cycles(4);
    chk("glitch_pre_sw", int'(sw_status), 4);
    pr_ctrl_status = 3'b100; cycle();
    pr_ctrl_status = 3'b010;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("glitch_no_err", int'(pr_err_pulse), 0);
      chk("glitch_sw", int'(sw_status), 4);
    end

    // Error priority and clear-with-start
    crc_err_in = 1; incompat_err_in = 1; pr_ctrl_status = 3'b100;
    cycles(2);
    cycle();
    chk("prio_err_pulse", int'(pr_err_pulse), 1);
    chk("prio_sw", int'(sw_status), 3);
    crc_err_in = 0; incompat_err_in = 0; pr_ctrl_status = 3'b010;
    cycles(4);
    chk("err_hold_sw", int'(sw_status), 3);
    sw_clr_err = 1; pr_start_req = 1; cycle();
    sw_clr_err = 0; pr_start_req = 0;
    chk("clr_start_nack", int'(start_nack), 1);
    chk("clr_idle_busy", int'(pr_busy), 0);
    chk("clr_idle_sw", int'(sw_status), 4);
    cycle();
    chk("nack_one_cycle", int'(start_nack), 0);

    // Watchdog
    pr_ctrl_status = 3'b001;
    cycles(3);
    pr_start_req = 1; cycle(); pr_start_req = 0;
    for (int k = 1; k <= T - 1; k++) begin
      cycle();
      chk("timeout_edge", int'(pr_err_pulse), (k == T - 1) ? 1 : 0);
    end
    chk("timeout_flag", int'(timeout_err), 1);
    chk("timeout_sw", int'(sw_status), 1);
    cycles(2);
    sw_clr_err = 1; cycle(); sw_clr_err = 0;
    chk("timeout_cleared", int'(timeout_err), 0);

    // Asynchronous reset in RUN
    pr_ctrl_status = 3'b010;
    cycles(3);
    pr_start_req = 1; cycle(); pr_start_req = 0;
    cycle();
    chk("pre_reset_run_sw", int'(sw_status), 4);
    mid_reset();
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    chk("post_reset_sw", int'(sw_status), 4);
    chk("post_reset_busy", int'(pr_busy), 0);

    // Randomized traffic
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        pr_ctrl_status = (r == 0) ? 3'd0 : (r == 1) ? 3'd4 : (r < 4) ? 3'd1 :
                         (r < 7) ? 3'd2 : 3'd3;
        hold = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 60);
      end else hold--;
      pr_start_req    = ($urandom_range(0, 15) == 0);
      sw_clr_err      = ($urandom_range(0, 11) == 0);
      crc_err_in      = ($urandom_range(0, 3) == 0);
      incompat_err_in = ($urandom_range(0, 5) == 0);
      if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
      cycle();
      if ($urandom_range(0, 599) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
